// File: rtl/req_index_encoder_if.sv
// Handshake bundle between a request producer, the index encoder and the index consumer.
// The slave modport is the encoder's view; master is the surrounding producer/consumer side.
interface req_index_encoder_if #(
   parameter int WIDTH = 8
);
   localparam int IDX_W = $clog2(WIDTH);

   logic [WIDTH-1:0] req_in;
   logic             req_valid;
   logic             rr_mode;
   logic             in_ready;
   logic [IDX_W-1:0] out_idx;
   logic             out_valid;
   logic             out_ready;
   logic             out_last;
   logic             out_multi;

   modport master (
      output req_in, req_valid, rr_mode, out_ready,
      input  in_ready, out_idx, out_valid, out_last, out_multi
   );

   modport slave (
      input  req_in, req_valid, rr_mode, out_ready,
      output in_ready, out_idx, out_valid, out_last, out_multi
   );
endinterface

// File: rtl/req_index_encoder.sv
// Captures a request vector and emits the index of every set bit, one per handshake,
// in fixed LSB-first or round-robin order.
module req_index_encoder #(
   parameter int WIDTH = 8
) (
   input logic              clk,
   input logic              rst,
   req_index_encoder_if.slave bus
);
   localparam int IDX_W = $clog2(WIDTH);
   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } state_t;

   state_t           state_r;
   state_t           state_next_s;
   logic [WIDTH-1:0] pending_r;
   logic [IDX_W-1:0] ptr_r;
   logic             mode_r;
   logic             multi_r;

   logic [IDX_W-1:0] low_s;
   logic [IDX_W-1:0] high_s;
   logic             high_hit_s;
   logic [IDX_W-1:0] sel_s;
   logic             single_s;
   logic             fire_s;

   function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] vec);
      logic [CNT_W-1:0] cnt;
      cnt = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt = cnt + CNT_W'(vec[i]);
      end
      return cnt;
   endfunction

   // Index search: lowest set bit overall, and lowest set bit strictly above ptr for round-robin.
   always_comb begin
      low_s      = '0;
      high_s     = '0;
      high_hit_s = 1'b0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         low_s      = pending_r[i] ? IDX_W'(i) : low_s;
         high_s     = (pending_r[i] && (i > int'(ptr_r))) ? IDX_W'(i) : high_s;
         high_hit_s = high_hit_s | (pending_r[i] && (i > int'(ptr_r)));
      end
      // Nothing above ptr means the search wraps to index 0, i.e. the lowest set bit.
      sel_s = (mode_r && high_hit_s) ? high_s : low_s;
   end

   assign single_s = (popcount(pending_r) == CNT_W'(1));
   assign fire_s   = (state_r == DRAIN) && bus.out_ready;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (bus.req_valid && (bus.req_in != {WIDTH{1'b0}})) begin
               state_next_s = DRAIN;
            end else begin
               state_next_s = IDLE;
            end
         end
         DRAIN: begin
            if (fire_s && single_s) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = DRAIN;
            end
         end
         default: state_next_s = IDLE;
      endcase
   end

   // Output decode; out_idx is forced to zero outside DRAIN.
   always_comb begin
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.out_idx   = '0;
      bus.out_last  = 1'b0;
      case (state_r)
         IDLE: begin
            bus.in_ready = 1'b1;
         end
         DRAIN: begin
            bus.out_valid = 1'b1;
            bus.out_idx   = sel_s;
            bus.out_last  = single_s;
         end
         default: begin
            bus.in_ready = 1'b1;
         end
      endcase
   end

   assign bus.out_multi = multi_r;

   // Capture and drain datapath; ptr survives across vectors so round-robin stays fair.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_r <= '0;
         ptr_r     <= IDX_W'(WIDTH - 1);
         mode_r    <= 1'b0;
         multi_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.req_valid) begin
                  pending_r <= bus.req_in;
                  mode_r    <= bus.rr_mode;
                  multi_r   <= (popcount(bus.req_in) >= CNT_W'(2));
               end
            end
            DRAIN: begin
               if (fire_s) begin
                  pending_r <= pending_r & ~({{(WIDTH - 1){1'b0}}, 1'b1} << sel_s);
                  ptr_r     <= sel_s;
                  if (single_s) begin
                     multi_r <= 1'b0;
                  end
               end
            end
            default: begin
               pending_r <= '0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_req_index_encoder.sv
// Directed bench for req_index_encoder: 8-bit instance for the main scenarios,
// 5-bit instance for non-power-of-two wrap and reset mid-drain.
module tb_req_index_encoder;
   logic clk = 1'b0;
   logic rst8 = 1'b1;
   logic rst5 = 1'b1;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   req_index_encoder_if #(.WIDTH(8)) bus8 ();
   req_index_encoder_if #(.WIDTH(5)) bus5 ();

   req_index_encoder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst8), .bus(bus8.slave));
   req_index_encoder #(.WIDTH(5)) dut5 (.clk(clk), .rst(rst5), .bus(bus5.slave));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cap8(input logic [7:0] vec, input logic mode);
      bus8.req_in = vec; bus8.rr_mode = mode; bus8.req_valid = 1'b1;
      step();
      bus8.req_valid = 1'b0;
   endtask

   task automatic cap5(input logic [4:0] vec, input logic mode);
      bus5.req_in = vec; bus5.rr_mode = mode; bus5.req_valid = 1'b1;
      step();
      bus5.req_valid = 1'b0;
   endtask

   task automatic test_reset();
      total++;
      if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0 || bus8.out_idx !== 3'd0 ||
          bus8.out_last !== 1'b0 || bus8.out_multi !== 1'b0) begin
         bad++;
         $display("FAIL reset_values got rdy=%b v=%b idx=%0d last=%b multi=%b exp 1 0 0 0 0",
                  bus8.in_ready, bus8.out_valid, bus8.out_idx, bus8.out_last, bus8.out_multi);
      end
      bus8.out_ready = 1'b0;
      cap8(8'hFF, 1'b0);
      total++;
      if (bus8.out_valid !== 1'b1 || bus8.out_multi !== 1'b1) begin
         bad++;
         $display("FAIL reset_pre_drain got v=%b multi=%b exp 1 1", bus8.out_valid, bus8.out_multi);
      end
      #2 rst8 = 1'b1;
      #1;
      total++;
      if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0 || bus8.out_idx !== 3'd0 ||
          bus8.out_multi !== 1'b0) begin
         bad++;
         $display("FAIL reset_async got rdy=%b v=%b idx=%0d multi=%b exp 1 0 0 0",
                  bus8.in_ready, bus8.out_valid, bus8.out_idx, bus8.out_multi);
      end
      #1 rst8 = 1'b0;
      bus8.out_ready = 1'b1;
      step();
   endtask

   task automatic test_fixed();
      logic [2:0] exp_idx [3] = '{3'd2, 3'd5, 3'd7};
      cap8(8'b1010_0100, 1'b0);
      for (int k = 0; k < 3; k++) begin
         total++;
         if (bus8.out_valid !== 1'b1 || bus8.in_ready !== 1'b0 || bus8.out_idx !== exp_idx[k] ||
             bus8.out_last !== (k == 2) || bus8.out_multi !== 1'b1) begin
            bad++;
            $display("FAIL fixed_drain[%0d] got v=%b rdy=%b idx=%0d last=%b multi=%b exp idx=%0d",
                     k, bus8.out_valid, bus8.in_ready, bus8.out_idx, bus8.out_last,
                     bus8.out_multi, exp_idx[k]);
         end
         step();
      end
      total++;
      if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0 || bus8.out_idx !== 3'd0 ||
          bus8.out_multi !== 1'b0) begin
         bad++;
         $display("FAIL fixed_done got rdy=%b v=%b idx=%0d multi=%b exp 1 0 0 0",
                  bus8.in_ready, bus8.out_valid, bus8.out_idx, bus8.out_multi);
      end
   endtask

   task automatic test_round_robin();
      logic [2:0] rr_exp [2] = '{3'd7, 3'd0};
      logic [2:0] fx_exp [2] = '{3'd0, 3'd7};
      cap8(8'b0000_0100, 1'b1);
      total++;
      if (bus8.out_idx !== 3'd2 || bus8.out_last !== 1'b1 || bus8.out_multi !== 1'b0) begin
         bad++;
         $display("FAIL rr_single got idx=%0d last=%b multi=%b exp 2 1 0",
                  bus8.out_idx, bus8.out_last, bus8.out_multi);
      end
      step();
      cap8(8'b1000_0001, 1'b1);
      for (int k = 0; k < 2; k++) begin
         total++;
         if (bus8.out_valid !== 1'b1 || bus8.out_idx !== rr_exp[k] || bus8.out_last !== (k == 1)) begin
            bad++;
            $display("FAIL rr_drain[%0d] got v=%b idx=%0d last=%b exp idx=%0d",
                     k, bus8.out_valid, bus8.out_idx, bus8.out_last, rr_exp[k]);
         end
         step();
      end
      cap8(8'b1000_0001, 1'b0);
      for (int k = 0; k < 2; k++) begin
         total++;
         if (bus8.out_valid !== 1'b1 || bus8.out_idx !== fx_exp[k] || bus8.out_last !== (k == 1)) begin
            bad++;
            $display("FAIL fixed_cmp[%0d] got v=%b idx=%0d last=%b exp idx=%0d",
                     k, bus8.out_valid, bus8.out_idx, bus8.out_last, fx_exp[k]);
         end
         step();
      end
      total++;
      if (bus8.in_ready !== 1'b1) begin
         bad++;
         $display("FAIL rr_done got rdy=%b exp 1", bus8.in_ready);
      end
   endtask

   task automatic test_backpressure();
      bus8.out_ready = 1'b0;
      cap8(8'b0001_0010, 1'b0);
      for (int k = 0; k < 3; k++) begin
         bus8.req_in = 8'hFF; bus8.req_valid = (k != 1);
         total++;
         if (bus8.out_valid !== 1'b1 || bus8.out_idx !== 3'd1 || bus8.out_last !== 1'b0 ||
             bus8.out_multi !== 1'b1) begin
            bad++;
            $display("FAIL bp_hold[%0d] got v=%b idx=%0d last=%b multi=%b exp 1 1 0 1",
                     k, bus8.out_valid, bus8.out_idx, bus8.out_last, bus8.out_multi);
         end
         step();
      end
      bus8.out_ready = 1'b1;
      bus8.req_valid = 1'b0;
      total++;
      if (bus8.out_idx !== 3'd1) begin
         bad++;
         $display("FAIL bp_release got idx=%0d exp 1", bus8.out_idx);
      end
      step();
      bus8.req_in = 8'h80; bus8.req_valid = 1'b1;
      total++;
      if (bus8.out_valid !== 1'b1 || bus8.out_idx !== 3'd4 || bus8.out_last !== 1'b1) begin
         bad++;
         $display("FAIL bp_second got v=%b idx=%0d last=%b exp 1 4 1",
                  bus8.out_valid, bus8.out_idx, bus8.out_last);
      end
      step();
      bus8.req_valid = 1'b0;
      step();
      total++;
      if (bus8.out_valid !== 1'b0 || bus8.in_ready !== 1'b1) begin
         bad++;
         $display("FAIL bp_no_queue got v=%b rdy=%b exp 0 1", bus8.out_valid, bus8.in_ready);
      end
   endtask

   task automatic test_zero_single();
      cap8(8'h00, 1'b0);
      total++;
      if (bus8.out_valid !== 1'b0 || bus8.in_ready !== 1'b1 || bus8.out_idx !== 3'd0) begin
         bad++;
         $display("FAIL zero_vec got v=%b rdy=%b idx=%0d exp 0 1 0",
                  bus8.out_valid, bus8.in_ready, bus8.out_idx);
      end
      cap8(8'h40, 1'b0);
      total++;
      if (bus8.out_valid !== 1'b1 || bus8.out_idx !== 3'd6 || bus8.out_last !== 1'b1 ||
          bus8.out_multi !== 1'b0) begin
         bad++;
         $display("FAIL single_hot got v=%b idx=%0d last=%b multi=%b exp 1 6 1 0",
                  bus8.out_valid, bus8.out_idx, bus8.out_last, bus8.out_multi);
      end
      step();
      total++;
      if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0) begin
         bad++;
         $display("FAIL single_done got rdy=%b v=%b exp 1 0", bus8.in_ready, bus8.out_valid);
      end
   endtask

   task automatic test_width5();
      logic [2:0] exp_idx [2] = '{3'd0, 3'd4};
      cap5(5'b1_0001, 1'b1);
      for (int k = 0; k < 2; k++) begin
         total++;
         if (bus5.out_valid !== 1'b1 || bus5.out_idx !== exp_idx[k] || bus5.out_last !== (k == 1) ||
             bus5.out_multi !== 1'b1) begin
            bad++;
            $display("FAIL w5_wrap[%0d] got v=%b idx=%0d last=%b multi=%b exp idx=%0d",
                     k, bus5.out_valid, bus5.out_idx, bus5.out_last, bus5.out_multi, exp_idx[k]);
         end
         step();
      end
      cap5(5'b1_0001, 1'b1);
      total++;
      if (bus5.out_idx !== 3'd0) begin
         bad++;
         $display("FAIL w5_first got idx=%0d exp 0", bus5.out_idx);
      end
      step();
      #2 rst5 = 1'b1;
      #1;
      total++;
      if (bus5.out_valid !== 1'b0 || bus5.out_idx !== 3'd0 || bus5.in_ready !== 1'b1 ||
          bus5.out_multi !== 1'b0) begin
         bad++;
         $display("FAIL w5_rst_mid got v=%b idx=%0d rdy=%b multi=%b exp 0 0 1 0",
                  bus5.out_valid, bus5.out_idx, bus5.in_ready, bus5.out_multi);
      end
      step();
      rst5 = 1'b0;
      step();
      total++;
      if (bus5.out_valid !== 1'b0) begin
         bad++;
         $display("FAIL w5_no_partial got v=%b exp 0", bus5.out_valid);
      end
      // ptr back at 4 means the round-robin search starts at 0 again.
      cap5(5'b1_0001, 1'b1);
      total++;
      if (bus5.out_valid !== 1'b1 || bus5.out_idx !== 3'd0) begin
         bad++;
         $display("FAIL w5_ptr_after_rst got v=%b idx=%0d exp 1 0", bus5.out_valid, bus5.out_idx);
      end
      step();
      step();
   endtask

   initial begin
      bus8.req_in = '0; bus8.req_valid = 1'b0; bus8.rr_mode = 1'b0; bus8.out_ready = 1'b1;
      bus5.req_in = '0; bus5.req_valid = 1'b0; bus5.rr_mode = 1'b0; bus5.out_ready = 1'b1;
      #12;
      test_reset_entry();
   end

   task automatic test_reset_entry();
      test_reset_checks_then_release();
      test_reset();
      test_fixed();
      test_round_robin();
      test_backpressure();
      test_zero_single();
      test_width5();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   endtask

   task automatic test_reset_checks_then_release();
      total++;
      if (bus5.in_ready !== 1'b1 || bus5.out_valid !== 1'b0 || bus5.out_idx !== 3'd0) begin
         bad++;
         $display("FAIL w5_reset got rdy=%b v=%b idx=%0d exp 1 0 0",
                  bus5.in_ready, bus5.out_valid, bus5.out_idx);
      end
      rst8 = 1'b0;
      rst5 = 1'b0;
      step();
   endtask
endmodule
